mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the core's single memory port between instruction fetch and load/store data access. Each requester uses a req/ack handshake. The arbiter registers the winning request onto the memory port and returns the memory's acknowledge and read data to the winner. It drives `stall_mem` to the datapath while either requester is waiting, and provides bounded fairness and a bus timeout.

## Interface
- `STARVE_MAX`, default 4: maximum number of consecutive data grants while a fetch is pending before fetch is forced.
- `TIMEOUT`, default 255: number of cycles in a busy state without `mem_ack` before the transaction is aborted with an error.
- `clk`  in  1  clock; everything is clocked on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held until `i_ack`.
- `i_addr`  in  32  fetch address (`nextPC`).
- `i_ack`  out  1  one-cycle pulse: fetch complete.
- `i_rdata`  out  32  instruction; valid only while `i_ack`.
- `d_req`  in  1  data request (`memory_en`); held until `d_ack`.
- `d_size`  in  2  00 = store byte, 01 = store half, 10 = store word, 11 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  32  load data; valid only while `d_ack`.
- `err`  out  1  asserted together with `i_ack`/`d_ack` when the transaction timed out.
- `stall_mem`  out  1  high while any request is pending and not acknowledged.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  write enable; equals `d_size != 11`.
- `mem_size`  out  2  size code, same encoding as `d_size`; fetch always drives 11.
- `mem_addr`  out  32  latched address.
- `mem_wdata`  out  32  latched store data.
- `mem_ack`  in  1  memory completion; considered only while `mem_req` is high.
- `mem_rdata`  in  32  read data; valid with `mem_ack`.

## Operation
- The FSM has three states: IDLE, BUSY_I and BUSY_D.
- **Grant, in IDLE:**
  - If only one request is pending, that requester is granted.
  - If both are pending, D is granted unless `starve_cnt == STARVE_MAX`, in which case I is granted.
  - On grant:
    - Latch address, size and wdata into the `mem_*` registers and set `mem_req = 1`.
    - Clear the timeout counter.
    - Go to BUSY_I or BUSY_D.
- **Starvation counter:**
  - Increments when D is granted while `i_req` is high.
  - Clears whenever I is granted.
  - Saturates at `STARVE_MAX`.
- **Completion, in BUSY_x:**
  - `x_ack = mem_ack`, combinationally.
  - `x_rdata = mem_rdata` while acked, otherwise 0.
  - On ack, go to IDLE and clear `mem_req`, `mem_we` and `mem_size` (to 11).
  - The latched `mem_addr`/`mem_wdata` are held.
- **Timeout:**
  - The counter increments every busy cycle.
  - When it reaches `TIMEOUT` without `mem_ack`: pulse `x_ack` and `err` with `x_rdata = 0`, drop `mem_req`, go to IDLE.
  - `mem_ack` in the same cycle as the timeout wins: normal ack, `err = 0`.
- **Requests while not granted:**
  - A requester's `req` is ignored in the cycle its ack is asserted.
  - `req` seen again in IDLE is treated as a new request.
- **Out-of-contract memory behaviour:** `mem_ack` in IDLE is ignored. A late ack after a timeout is a memory contract violation and is not detected.
- **`stall_mem`:** `(i_req & ~i_ack) | (d_req & ~d_ack)`, purely combinational.
- **Reset:**
  - State goes to IDLE; `starve_cnt`, the timeout counter, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` go to 0; `mem_size` goes to 11.
  - `i_ack`, `d_ack`, `err`, `i_rdata` and `d_rdata` read 0 after reset.
  - A transaction in flight is abandoned with no ack.

## Timing
- A request seen in IDLE at cycle N gives `mem_req` high at N+1 with the latched fields.
- Minimum latency: `mem_ack` at N+1 gives `x_ack` at N+1.
- An ack at cycle M means IDLE at M+1. The next grant is evaluated at M+1, so the next `mem_req` rises at M+2. There is exactly one idle bus cycle between transactions.
- The `mem_*` outputs are stable for the whole busy period.
- An aborted transaction completes `TIMEOUT` cycles after `mem_req` rose.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, BUSY_I, BUSY_D);
  - size constants `SIZE_B = 2'b00`, `SIZE_H = 2'b01`, `SIZE_W = 2'b10`, `SIZE_RD = 2'b11`.
- No sub-module; the FSM, starvation counter and timeout counter are inline.
- Counter widths are `$clog2(STARVE_MAX+1)` and `$clog2(TIMEOUT+1)`.

## Test plan
- **Fetch only:** `i_req` with `i_addr = 0x100`; memory acks 2 cycles after `mem_req`, `mem_rdata = 0x00500093`. Required: `mem_size = 11`, `mem_we = 0`, `mem_addr = 0x100`; `i_ack` for one cycle with `i_rdata = 0x00500093`; `stall_mem` high until the ack cycle.
- **Store byte:** `d_size = 00`, `d_addr = 0x2003`, `d_wdata = 0xAB`. Required: `mem_we = 1`, `mem_size = 00`, `mem_wdata = 0xAB`; `d_ack` one pulse; `mem_req` low the next cycle.
- **Simultaneous requests:** both raised in the same cycle. Required: D served first; I granted the cycle after `d_ack`; `mem_req` low for exactly one cycle between the two transactions.
- **Starvation:** `d_req` held continuously with `i_req` high, `STARVE_MAX = 4`. Required: 4 D grants, then 1 I grant, then D resumes.
- **Timeout:** memory never acks, `TIMEOUT = 8`. Required: `d_ack` and `err` pulse 8 cycles after `mem_req` rose, `d_rdata = 0`. Repeat with `mem_ack` on cycle 8: required normal ack with `err = 0`.
- **Reset mid-transaction:** assert `reset` while in BUSY_D, then pulse `mem_ack`. Required: next cycle `mem_req = 0` and IDLE; no `d_ack`; the following request is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State encoding and memory size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_B  = 2'b00;
  localparam logic [1:0] SIZE_H  = 2'b01;
  localparam logic [1:0] SIZE_W  = 2'b10;
  localparam logic [1:0] SIZE_RD = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetch and load/store,
// with bounded fetch starvation and a bus timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] S_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT);

  arb_state_e    state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic          grant_i, grant_d;
  logic          ack_v, tout, done;

  assign ack_v = mem_ack & mem_req;
  assign tout  = (tcnt == T_LIM);

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        // Data wins ties until fetch has waited STARVE_MAX grants
        if (d_req && !(i_req && starve_cnt == S_LIM)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I: begin
        done    = ack_v | tout;
        i_ack   = done;
        i_rdata = ack_v ? mem_rdata : '0;
        err     = tout & ~ack_v;
        if (done) state_nxt = IDLE;
      end
      BUSY_D: begin
        done    = ack_v | tout;
        d_ack   = done;
        d_rdata = ack_v ? mem_rdata : '0;
        err     = tout & ~ack_v;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_mem = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tcnt       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= SIZE_RD;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= (d_size != SIZE_RD);
        mem_size  <= d_size;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        tcnt      <= '0;
        if (i_req && starve_cnt != S_LIM)
          starve_cnt <= starve_cnt + SW'(1);
      end else if (grant_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_size   <= SIZE_RD;
        mem_addr   <= i_addr;
        tcnt       <= '0;
        starve_cnt <= '0;
      end else if (done) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        mem_size <= SIZE_RD;
      end else if (state != IDLE) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Inputs change #1 after posedge, outputs are sampled at negedge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .err(err), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 0; i_addr = 0;
    d_req = 0; d_size = 2'b11;
    d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    step(); step();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req got %b/%b want 0/0", mem_req, mem_we);
    end
    n_chk++;
    if (mem_size !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_size got %b want 11", mem_size);
    end
    n_chk++;
    if (mem_addr !== 0 || mem_wdata !== 0) begin
      n_fail++;
      $display("FAIL rst_addr got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    n_chk++;
    if ({i_ack, d_ack, err, stall_mem} !== 4'b0 ||
        i_rdata !== 0 || d_rdata !== 0) begin
      n_fail++;
      $display("FAIL rst_acks got %b want 0000",
               {i_ack, d_ack, err, stall_mem});
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    n_chk++;
    if (stall_mem !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL f_req got stall=%b req=%b want 1/0",
               stall_mem, mem_req);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1 || mem_size !== 2'b11 || mem_we !== 0 ||
        mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL f_bus got %b %b %b %h want 1 11 0 100",
               mem_req, mem_size, mem_we, mem_addr);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (i_ack !== 0 || stall_mem !== 1) begin
      n_fail++;
      $display("FAIL f_wait got ack=%b stall=%b want 0/1", i_ack, stall_mem);
    end
    step();
    mem_ack = 1; mem_rdata = 32'h00500093;
    @(negedge clk);
    n_chk++;
    if (i_ack !== 1 || i_rdata !== 32'h00500093 ||
        stall_mem !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL f_ack got %b %h %b %b want 1 00500093 0 0",
               i_ack, i_rdata, stall_mem, err);
    end
    step();
    i_req = 0; mem_ack = 0;
    @(negedge clk);
    n_chk++;
    if (i_ack !== 0 || mem_req !== 0 || i_rdata !== 0) begin
      n_fail++;
      $display("FAIL f_after got ack=%b req=%b want 0/0", i_ack, mem_req);
    end
    step();
  endtask

  task automatic test_store();
    d_req = 1; d_size = 2'b00;
    d_addr = 32'h2003; d_wdata = 32'hAB;
    step();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1 || mem_we !== 1 || mem_size !== 2'b00 ||
        mem_wdata !== 32'hAB || mem_addr !== 32'h2003) begin
      n_fail++;
      $display("FAIL sb_bus got %b %b %b %h %h want 1 1 00 ab 2003",
               mem_req, mem_we, mem_size, mem_wdata, mem_addr);
    end
    mem_ack = 1;
    #1;
    n_chk++;
    if (d_ack !== 1 || i_ack !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL sb_ack got d=%b i=%b e=%b want 1 0 0",
               d_ack, i_ack, err);
    end
    step();
    d_req = 0; mem_ack = 0;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 0 || d_ack !== 0 || mem_we !== 0 ||
        mem_size !== 2'b11 || mem_addr !== 32'h2003) begin
      n_fail++;
      $display("FAIL sb_after got %b %b %b %b %h want 0 0 0 11 2003",
               mem_req, d_ack, mem_we, mem_size, mem_addr);
    end
    step();
  endtask

  task automatic test_simultaneous();
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_size = 2'b11; d_addr = 32'h3000;
    step();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1 || mem_addr !== 32'h3000 || mem_we !== 0) begin
      n_fail++;
      $display("FAIL sim_d got req=%b addr=%h we=%b want 1 3000 0",
               mem_req, mem_addr, mem_we);
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (d_ack !== 1 || d_rdata !== 32'hDEADBEEF ||
        i_ack !== 0 || stall_mem !== 1) begin
      n_fail++;
      $display("FAIL sim_dack got %b %h %b %b want 1 deadbeef 0 1",
               d_ack, d_rdata, i_ack, stall_mem);
    end
    step();
    d_req = 0; mem_ack = 0;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 0 || stall_mem !== 1) begin
      n_fail++;
      $display("FAIL sim_gap got req=%b stall=%b want 0/1", mem_req, stall_mem);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1 || mem_addr !== 32'h200 || mem_size !== 2'b11) begin
      n_fail++;
      $display("FAIL sim_i got req=%b addr=%h want 1 200", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h13;
    #1;
    n_chk++;
    if (i_ack !== 1 || i_rdata !== 32'h13 || d_ack !== 0) begin
      n_fail++;
      $display("FAIL sim_iack got %b %h %b want 1 13 0",
               i_ack, i_rdata, d_ack);
    end
    step();
    i_req = 0; mem_ack = 0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] want [6];
    int k = 0;
    int cyc = 0;
    want = '{32'h5000, 32'h5000, 32'h5000, 32'h5000,
             32'h400, 32'h5000};
    i_req = 1; i_addr = 32'h400;
    d_req = 1; d_size = 2'b11; d_addr = 32'h5000;
    while (k < 6 && cyc < 60) begin
      @(negedge clk);
      if (mem_req) begin
        n_chk++;
        if (mem_addr !== want[k]) begin
          n_fail++;
          $display("FAIL starve_%0d got %h want %h", k, mem_addr, want[k]);
        end
        mem_ack = 1;
        k++;
      end
      step();
      mem_ack = 0;
      cyc++;
    end
    n_chk++;
    if (k != 6) begin
      n_fail++;
      $display("FAIL starve_grants got %0d want 6", k);
    end
    i_req = 0; d_req = 0;
    step(); step();
  endtask

  task automatic test_timeout(input logic ack_last);
    d_req = 1; d_size = 2'b11; d_addr = 32'h6000;
    mem_rdata = 32'h1234;
    step();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1) begin
      n_fail++;
      $display("FAIL to_req got %b want 1", mem_req);
    end
    for (int c = 1; c < 8; c++) begin
      step();
      @(negedge clk);
      n_chk++;
      if (d_ack !== 0 || mem_req !== 1) begin
        n_fail++;
        $display("FAIL to_wait_%0d got ack=%b req=%b want 0/1",
                 c, d_ack, mem_req);
      end
    end
    step();
    mem_ack = ack_last;
    @(negedge clk);
    n_chk++;
    if (d_ack !== 1 || err !== !ack_last ||
        d_rdata !== (ack_last ? 32'h1234 : 32'h0)) begin
      n_fail++;
      $display("FAIL to_end got ack=%b err=%b rd=%h want 1 %b (ack_last=%b)",
               d_ack, err, d_rdata, !ack_last, ack_last);
    end
    step();
    d_req = 0; mem_ack = 0;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 0 || d_ack !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL to_after got req=%b ack=%b err=%b want 0",
               mem_req, d_ack, err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_size = 2'b10;
    d_addr = 32'h7000; d_wdata = 32'h55;
    step();
    step();
    reset = 1;
    step();
    reset = 0; mem_ack = 1;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 0 || d_ack !== 0 || mem_addr !== 0) begin
      n_fail++;
      $display("FAIL rm_idle got req=%b ack=%b addr=%h want 0 0 0",
               mem_req, d_ack, mem_addr);
    end
    step();
    mem_ack = 0;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1 || mem_addr !== 32'h7000 ||
        mem_we !== 1 || mem_size !== 2'b10 || mem_wdata !== 32'h55) begin
      n_fail++;
      $display("FAIL rm_regrant got %b %h %b %b want 1 7000 1 10",
               mem_req, mem_addr, mem_we, mem_size);
    end
    mem_ack = 1;
    #1;
    n_chk++;
    if (d_ack !== 1 || err !== 0) begin
      n_fail++;
      $display("FAIL rm_ack got ack=%b err=%b want 1/0", d_ack, err);
    end
    step();
    d_req = 0; mem_ack = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
